printer_spooler: RTL and testbench

Byte spooler sitting between the printer serial receiver (714 baud, one-cycle byte-valid strobe) and the 115200-baud UART transmitter. Buffers received bytes in a FIFO and feeds them to the transmitter one at a time with a request/ready handshake. Raises a flow-control hold as the FIFO fills, flags overflow, and can optionally expand CR to CR LF. Single clock domain, 50 MHz system clock.

---
 rtl/printer_pkg.sv | 18 +
 rtl/spool_fifo.sv | 70 +++++++
 rtl/printer_spooler.sv | 135 +++++++++++++
 tb/tb_printer_spooler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/printer_pkg.sv
// Shared types and constants for the printer byte spooler and its serial neighbours.
package printer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StSettle,
        StWaitDone
    } spool_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 50 MHz system clock divided down to 115200 baud (transmitter) and 714 baud (receiver).
    localparam int unsigned TX_BAUD_DIV = 434;
    localparam int unsigned RX_BAUD_DIV = 70028;

endpackage

// File: rtl/spool_fifo.sv
// Register-array byte FIFO; pointers carry an extra wrap bit so occupancy is a plain subtraction.
module spool_fifo
    import printer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    rdata_o,
    output logic [LW-1:0] level_o,
    output logic [LW-1:0] level_next_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == LW'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);

    // A pop frees the slot the same-cycle push lands in, so full+pop still accepts the byte.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + LW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + LW'(1);
            end
        end
    end

    assign level_next_o = wptr_d - rptr_d;
    assign rdata_o      = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/printer_spooler.sv
// Byte spooler between the printer receiver and the UART transmitter, with hold and overflow.
// Define PRINTER_CRLF_EN to expand every transmitted CR into CR LF.
module printer_spooler
    import printer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HOLD_LEVEL = 12,
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          flush_i,
    input  logic          tx_ready_i,
    output logic          tx_req_o,
    output logic [7:0]    tx_data_o,
    output logic          hold_o,
    output logic          overflow_o,
    output logic [LW-1:0] level_o
);

    localparam logic [LW-1:0] HoldLvl = LW'(HOLD_LEVEL);

    spool_state_t  state_q;
    logic          tx_req_q;
    logic [7:0]    tx_data_q;
    logic          hold_q;
    logic          overflow_q;

    logic [7:0]    head;
    logic [LW-1:0] level, level_next;
    logic          full, empty;
    logic          lf_pend, idle_go, lf_go, pop, drop;

    // Flush wins over any issue decision taken in the same cycle.
    assign idle_go = (state_q == StIdle) && tx_ready_i && !flush_i;
    assign lf_go   = idle_go && lf_pend;
    assign pop     = idle_go && !lf_pend && !empty;
    assign drop    = rx_valid_i && full && !pop && !flush_i;

    spool_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (rx_valid_i),
        .wdata_i      (rx_byte_i),
        .pop_i        (pop),
        .flush_i      (flush_i),
        .rdata_o      (head),
        .level_o      (level),
        .level_next_o (level_next),
        .full_o       (full),
        .empty_o      (empty)
    );

`ifdef PRINTER_CRLF_EN
    logic lf_pend_q;

    // An LF is owed once a CR has actually gone out on tx_req; it is not a FIFO entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lf_pend_q <= 1'b0;
        end else if (flush_i || lf_go) begin
            lf_pend_q <= 1'b0;
        end else if ((state_q == StIssue) && (tx_data_q == ASCII_CR)) begin
            lf_pend_q <= 1'b1;
        end
    end

    assign lf_pend = lf_pend_q;
`else
    assign lf_pend = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_req_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (lf_go) begin
                        tx_data_q <= ASCII_LF;
                        tx_req_q  <= 1'b1;
                        state_q   <= StIssue;
                    end else if (pop) begin
                        tx_data_q <= head;
                        tx_req_q  <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StSettle;
                end
                // The transmitter may not have dropped tx_ready yet, so it is ignored here.
                StSettle: begin
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (tx_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            hold_q <= (level_next >= HoldLvl);
            if (flush_i) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx_req_o   = tx_req_q;
    assign tx_data_o  = tx_data_q;
    assign hold_o     = hold_q;
    assign overflow_o = overflow_q;
    assign level_o    = level;

endmodule

// File: tb/tb_printer_spooler.sv
// Self-checking bench for printer_spooler: queue-based reference model plus directed scenarios.
module tb_printer_spooler;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HOLD  = 12;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef PRINTER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          rx_valid   = 1'b0;
    logic [7:0]    rx_byte    = 8'h00;
    logic          flush      = 1'b0;
    logic          stall      = 1'b0;
    logic          xmit_ready = 1'b1;
    logic          tx_ready;
    logic          tx_req;
    logic [7:0]    tx_data;
    logic          hold;
    logic          overflow;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;
    int tx_lo  = 2;
    int tx_hi  = 6;

    assign tx_ready = xmit_ready && !stall;

    always #10 clk = ~clk;

    printer_spooler #(
        .DEPTH      (DEPTH),
        .HOLD_LEVEL (HOLD)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_valid_i (rx_valid),
        .rx_byte_i  (rx_byte),
        .flush_i    (flush),
        .tx_ready_i (tx_ready),
        .tx_req_o   (tx_req),
        .tx_data_o  (tx_data),
        .hold_o     (hold),
        .overflow_o (overflow),
        .level_o    (level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a byte queue plus "a frame lasts at least three cycles and ends on the
    // first tx_ready seen from its third cycle on". Outputs are what the DUT must show next cycle.
    logic [7:0] mq[$];
    logic       exp_req   = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_level = 0;
    logic       exp_hold  = 1'b0;
    logic       exp_ovf   = 1'b0;
    logic       lf_pend   = 1'b0;
    logic       busy      = 1'b0;
    int         since     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_req   <= 1'b0;
            exp_data  <= 8'h00;
            exp_level <= 0;
            exp_hold  <= 1'b0;
            exp_ovf   <= 1'b0;
            lf_pend   <= 1'b0;
            busy      <= 1'b0;
            since     <= 0;
        end else begin
            automatic bit       issue  = 1'b0;
            automatic bit       popped = 1'b0;
            automatic logic [7:0] nd   = exp_data;
            automatic int       n0     = mq.size();
            automatic bit       lf_n   = lf_pend;
            automatic bit       ovf_n  = exp_ovf;
            if (flush) begin
                mq.delete();
                ovf_n = 1'b0;
                lf_n  = 1'b0;
            end else begin
                if (!busy && tx_ready) begin
                    if (lf_pend) begin
                        issue = 1'b1;
                        nd    = 8'h0A;
                        lf_n  = 1'b0;
                    end else if (n0 > 0) begin
                        issue  = 1'b1;
                        popped = 1'b1;
                        nd     = mq.pop_front();
                        if (CRLF && nd == 8'h0D) lf_n = 1'b1;
                    end
                end
                if (rx_valid) begin
                    if (n0 < DEPTH || popped) mq.push_back(rx_byte);
                    else ovf_n = 1'b1;
                end
            end
            if (issue) begin
                busy  <= 1'b1;
                since <= 0;
            end else if (busy) begin
                since <= since + 1;
                if (since >= 2 && tx_ready) busy <= 1'b0;
            end
            exp_req   <= issue;
            exp_data  <= nd;
            exp_level <= mq.size();
            exp_hold  <= (mq.size() >= HOLD);
            exp_ovf   <= ovf_n;
            lf_pend   <= lf_n;
        end
    end

    // Per-cycle comparison and log of transmitted bytes.
    logic [7:0] sent[$];
    int cyc      = 0;
    int last_req = -100;

    always @(negedge clk) begin
        cyc++;
        chk("tx_req", tx_req, exp_req);
        chk("tx_data", tx_data, exp_data);
        chk("level", level, exp_level);
        chk("hold", hold, exp_hold);
        chk("overflow", overflow, exp_ovf);
        if (tx_req && rst_n) begin
            chk("req_spacing_ge4", int'(cyc - last_req >= 4), 1);
            last_req = cyc;
            sent.push_back(tx_data);
        end
    end

    // Transmitter: drops ready the cycle after a request, stays busy for a random time.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req) begin
                @(posedge clk);
                #1 xmit_ready = 1'b0;
                repeat ($urandom_range(tx_lo, tx_hi)) @(posedge clk);
                #1 xmit_ready = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(!busy && exp_level == 0 && !lf_pend && xmit_ready && !stall) && n < limit) begin
            step();
            n++;
        end
        chk("drain_within_budget", int'(!busy && exp_level == 0 && !lf_pend), 1);
    endtask

    task automatic push_burst(input logic [7:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            rx_byte  = 8'(base + i);
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_seq[$];
        int n0;

        // Reset values while reset is held.
        @(negedge clk);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_level", level, 0);
        chk("rst_hold", hold, 0);
        chk("rst_overflow", overflow, 0);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Single byte: request exactly two cycles after the strobe.
        rx_byte  = 8'h41;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t1_req_c1", tx_req, 0);
        chk("t1_level_c1", level, 1);
        chk("t1_model_level_c1", exp_level, 1);
        step();
        @(negedge clk);
        chk("t1_req_c2", tx_req, 1);
        chk("t1_data_c2", tx_data, 8'h41);
        chk("t1_level_c2", level, 0);
        chk("t1_model_req_c2", exp_req, 1);
        wait_idle(100);

        // Fill with the transmitter stalled: 17 pushes into 16 entries.
        stall = 1'b1;
        step();
        sent.delete();
        for (int i = 0; i < 17; i++) begin
            rx_byte  = 8'(8'h60 + i);
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
            @(negedge clk);
            chk("fill_hold", hold, int'(i >= 11));
            chk("fill_level", level, (i < 16) ? i + 1 : 16);
        end
        chk("fill_level_final", level, 16);
        chk("fill_overflow", overflow, 1);
        chk("fill_model_ovf", exp_ovf, 1);
        step();
        stall = 1'b0;
        wait_idle(600);
        chk("drain_count", sent.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", (i < sent.size()) ? int'(sent[i]) : 'h1FF, 8'h60 + i);
        end

        // CR followed by an ordinary byte.
        sent.delete();
        rx_byte  = 8'h0D;
        rx_valid = 1'b1;
        step();
        rx_byte  = 8'h42;
        step();
        rx_valid = 1'b0;
        step();
        wait_idle(200);
        exp_seq.delete();
        exp_seq.push_back(8'h0D);
        if (CRLF) exp_seq.push_back(8'h0A);
        exp_seq.push_back(8'h42);
        chk("crlf_count", sent.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++) begin
            chk("crlf_seq", (i < sent.size()) ? int'(sent[i]) : 'h1FF, exp_seq[i]);
        end

        // Flush while a byte is in flight and five more are queued.
        tx_lo = 40;
        tx_hi = 40;
        push_burst(8'h20, 6);
        @(negedge clk);
        chk("flush_pre_level", level, 5);
        chk("flush_pre_overflow", overflow, 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_level", level, 0);
        chk("flush_overflow", overflow, 0);
        n0 = sent.size();
        repeat (100) step();
        chk("flush_no_more_req", sent.size() - n0, 0);

        // Reset mid-frame with three bytes queued.
        push_burst(8'h30, 4);
        @(negedge clk);
        chk("rst_pre_level", level, 3);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", tx_req, 0);
        chk("rst_async_level", level, 0);
        chk("rst_async_hold", hold, 0);
        step();
        step();
        rst_n = 1'b1;
        n0 = sent.size();
        repeat (80) step();
        chk("rst_no_req_after", sent.size() - n0, 0);

        // Randomised traffic with occasional flushes and transmitter stalls.
        tx_lo = 1;
        tx_hi = 8;
        for (int c = 0; c < 4000; c++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_byte  = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            flush    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) stall = ~stall;
            step();
        end
        rx_valid = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
